rat_path_player: RTL
====================

// Module: rat_path_player
// PURPOSE
// - Downstream consumer of the rat solver's path queue: pops 2-bit move opcodes after the solve completes.
// - Replays the moves from (0,0) at a programmable pace and drives a live position for display/LEDs.
// - Reports the move count, arrival at the goal cell, and any move that would leave the grid.
// PARAMETERS
// - STEP_CYCLES  4   cycles per replayed move (>=2); sets the display pacing
// - CNT_W        8   width of move_count
// - GOAL_X       15  goal column
// - GOAL_Y       15  goal row
// PORTS
// - clk         in   1      clock; single clock domain
// - rst         in   1      synchronous, active-high reset
// - run         in   1      start playback (level; sampled in IDLE only)
// - q_empty     in   1      path queue empty
// - q_out       in   2      head of queue; first-word fall-through, valid while q_empty=0
// - dequeue     out  1      pop queue head at this clock edge
// - pos_x       out  4      current replay column
// - pos_y       out  4      current replay row
// - step_valid  out  1      1-cycle pulse: pos_x/pos_y just updated
// - move_count  out  CNT_W  moves applied since the last start
// - busy        out  1      playback in progress
// - play_done   out  1      1-cycle pulse: playback finished (normally or on error)
// - arrived     out  1      level: last playback ended on (GOAL_X,GOAL_Y)
// - err_oob     out  1      level: a move would leave the 0..15 grid
// BEHAVIOUR
// - Opcode map: 00 x+1, 01 y+1, 10 x-1, 11 y-1. Coordinates are unsigned 4-bit; no wrap.
// - Reset: state=IDLE; all outputs 0 (pos 0,0; move_count 0; flags 0).
// - rst asserted mid-playback: the next edge returns the block to IDLE with reset values.
//   The block issues no further dequeue.
// - FSM states:
//   - IDLE: busy=0.
//     - run=1: clear pos, move_count, arrived and err_oob; go to FETCH.
//   - FETCH: busy=1.
//     - q_empty=1: go to FIN.
//     - Otherwise: latch q_out into mv_r; dequeue=1 for exactly this cycle; go to APPLY.
//   - APPLY: compute the next position from mv_r.
//     - The move leaves the grid (x=15 with 00, y=15 with 01, x=0 with 10, y=0 with 11):
//       pos is unchanged, err_oob<=1, go to FIN.
//     - Otherwise: update pos; step_valid=1; move_count+1, saturating at all-ones;
//       go to HOLD; the pace counter loads STEP_CYCLES-2.
//   - HOLD: decrement the pace counter; at 0 go to FETCH.
//     Move period = STEP_CYCLES cycles (FETCH + APPLY + HOLD time).
//   - FIN: play_done=1 for one cycle.
//     - arrived <= (pos==GOAL) & ~err_oob.
//     - Go to IDLE.
// - Flags: arrived and err_oob hold until the next start or rst.
// - run held high across FIN->IDLE starts a new playback.
//   The queue is then normally empty, so the block goes IDLE->FETCH->FIN with move_count 0.
// - Concurrent events:
//   - run is ignored outside IDLE.
//   - dequeue is never asserted when q_empty=1.
//   - At most one dequeue per STEP_CYCLES cycles.
// - On error, leftover queue entries are not drained.
//   Upstream clears them through its own reset/INIT path.
// - Latency: run to the first step_valid is 3 cycles (IDLE->FETCH->APPLY, pulse in APPLY).
// TESTING
// - Queue {00,01}, run=1 -> two dequeue pulses 4 cycles apart.
//   step_valid with pos (1,0) then (1,1); move_count=2; play_done; arrived=0.
// - Queue of 15x00 then 15x01 -> final pos (15,15); move_count=30; arrived=1; err_oob=0.
// - Queue {10} from (0,0) -> err_oob=1; pos stays (0,0); play_done; arrived=0; 0 step_valid.
// - q_empty=1 at run -> play_done 2 cycles after run; move_count=0; dequeue never asserted.
// - rst during HOLD of the 3rd move -> next cycle all outputs 0, state IDLE, no further dequeue.
// - STEP_CYCLES=2, 300 moves alternating 00/10 -> move_count saturates at 255;
//   dequeue spacing exactly 2 cycles.

Source files
------------

// File: rtl/rat_path_player.sv
`default_nettype none
// ============================================================================
//  Module      : rat_path_player
//  Description : Replays 2-bit move opcodes popped from the solver's path
//                queue, pacing one move every STEP_CYCLES cycles from (0,0).
//  Revision    : 1.0 - initial release
// ============================================================================
module rat_path_player #(
    parameter int unsigned    STEP_CYCLES = 4,
    parameter int unsigned    CNT_W       = 8,
    parameter logic [3:0]     GOAL_X      = 4'd15,
    parameter logic [3:0]     GOAL_Y      = 4'd15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             q_empty,
    input  logic [1:0]       q_out,
    output logic             dequeue,
    output logic [3:0]       pos_x,
    output logic [3:0]       pos_y,
    output logic             step_valid,
    output logic [CNT_W-1:0] move_count,
    output logic             busy,
    output logic             play_done,
    output logic             arrived,
    output logic             err_oob
);

    localparam int unsigned           PACE_W    = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PACE_W-1:0]     PACE_LOAD = PACE_W'(STEP_CYCLES - 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_APPLY = 3'd2,
        S_HOLD  = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         mv_q, mv_d;
    logic [3:0]         pos_x_q, pos_x_d;
    logic [3:0]         pos_y_q, pos_y_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PACE_W-1:0]  pace_q, pace_d;
    logic               step_valid_q, step_valid_d;
    logic               arrived_q, arrived_d;
    logic               err_q, err_d;

    logic [3:0]         next_x;
    logic [3:0]         next_y;
    logic               leaves_grid;

    // Candidate position for the latched move; coordinates never wrap.
    always_comb begin
        next_x      = pos_x_q;
        next_y      = pos_y_q;
        leaves_grid = 1'b0;
        case (mv_q)
            2'b00: begin leaves_grid = (pos_x_q == 4'd15); next_x = pos_x_q + 4'd1; end
            2'b01: begin leaves_grid = (pos_y_q == 4'd15); next_y = pos_y_q + 4'd1; end
            2'b10: begin leaves_grid = (pos_x_q == 4'd0);  next_x = pos_x_q - 4'd1; end
            default: begin leaves_grid = (pos_y_q == 4'd0); next_y = pos_y_q - 4'd1; end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        mv_d         = mv_q;
        pos_x_d      = pos_x_q;
        pos_y_d      = pos_y_q;
        cnt_d        = cnt_q;
        pace_d       = pace_q;
        step_valid_d = 1'b0;
        arrived_d    = arrived_q;
        err_d        = err_q;
        dequeue      = 1'b0;
        play_done    = 1'b0;
        busy         = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    pos_x_d   = 4'd0;
                    pos_y_d   = 4'd0;
                    cnt_d     = '0;
                    arrived_d = 1'b0;
                    err_d     = 1'b0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                if (q_empty) begin
                    state_d = S_FIN;
                end else begin
                    mv_d    = q_out;
                    dequeue = 1'b1;
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                if (leaves_grid) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    pos_x_d      = next_x;
                    pos_y_d      = next_y;
                    step_valid_d = 1'b1;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    pace_d = PACE_LOAD;
                    // With a two-cycle period there is no hold time at all.
                    state_d = (PACE_LOAD == '0) ? S_FETCH : S_HOLD;
                end
            end
            S_HOLD: begin
                pace_d = pace_q - PACE_W'(1);
                if (pace_d == '0) begin
                    state_d = S_FETCH;
                end
            end
            S_FIN: begin
                play_done = 1'b1;
                arrived_d = (pos_x_q == GOAL_X) && (pos_y_q == GOAL_Y) && !err_q;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mv_q         <= 2'b00;
            pos_x_q      <= 4'd0;
            pos_y_q      <= 4'd0;
            cnt_q        <= '0;
            pace_q       <= '0;
            step_valid_q <= 1'b0;
            arrived_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mv_q         <= mv_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            cnt_q        <= cnt_d;
            pace_q       <= pace_d;
            step_valid_q <= step_valid_d;
            arrived_q    <= arrived_d;
            err_q        <= err_d;
        end
    end

    assign pos_x      = pos_x_q;
    assign pos_y      = pos_y_q;
    assign step_valid = step_valid_q;
    assign move_count = cnt_q;
    assign arrived    = arrived_q;
    assign err_oob    = err_q;

endmodule
`default_nettype wire
